instr_sequencer: RTL and testbench

Instruction sequencer that drives the processor datapath's control unit from a small loadable program buffer. It sits upstream of the control unit. It fetches 16-bit instruction words in order, presents each one with a one-cycle `run` strobe, and holds it stable until the control unit signals completion on `done`. It then advances the program counter, and raises `finished` after the last word or `error` if the control unit stops responding.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/prog_mem.sv | 32 +++
 rtl/instr_sequencer.sv | 139 +++++++++++++
 tb/tb_instr_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERR    = 3'd5
  } seq_state_t;

  localparam int INSTR_W = 16;

  // Instruction field positions as seen by the control unit.
  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 13;
  localparam int SRC_MSB  = 12;
  localparam int SRC_LSB  = 10;
  localparam int ALU_MSB  = 6;
  localparam int ALU_LSB  = 3;
  localparam int MODE_BIT = 2;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/prog_mem.sv
// Program buffer: DEPTH x 16 words, synchronous write, registered read with enable.
module prog_mem
  import seq_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Store a program word.
  // NOTE: the array has no reset branch so it maps onto plain RAM; software loads it before use.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read port register; it only updates when asked, so it doubles as the held instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches program words in order, issues each with a one-cycle run strobe and
// waits for a rising edge of done before moving on; aborts if done never comes.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [LW-1:0]      prog_len,
  input  logic               start,
  input  logic               done,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               finished,
  output logic               error
);

  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  // Last counter value still allowed in WAIT; one more idle cycle aborts.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [LW-1:0]    len_q, len_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             done_d;
  logic             done_rise;
  logic             rd_en;
  logic             mem_we;
  logic             last_word;
  logic [LW-1:0]    len_clamped;

  assign done_rise   = done & ~done_d;
  assign last_word   = ({1'b0, pc_q} == (len_q - LW'(1)));
  assign len_clamped = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign mem_we      = prog_we & ~busy;
  assign pc          = pc_q;

  prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_en   (rd_en),
    .rd_addr (pc_q),
    .rd_data (instruction)
  );

  // State, program counter, length, timeout counter and done history.
  // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      done_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      done_d  <= done;
    end
  end

  // Next-state decode and state-derived outputs.
  // NOTE: every output of this block is given a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    tmo_d    = tmo_q;
    rd_en    = 1'b0;
    run      = 1'b0;
    busy     = 1'b1;
    finished = 1'b0;
    error    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (prog_len == '0) begin
            state_d = S_FINISH;
          end else begin
            len_d   = len_clamped;
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        run     = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          if (last_word) begin
            state_d = S_FINISH;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_FINISH: begin
        finished = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed scenarios plus randomized programs, each run
// compared against a cycle schedule derived from the sequencing rules.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [LW-1:0] prog_len;
  logic          start;
  logic          done;
  logic [15:0]   instruction;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench's own picture of the program buffer.
  logic [15:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .done        (done),
    .instruction (instruction),
    .run         (run),
    .pc          (pc),
    .busy        (busy),
    .finished    (finished),
    .error       (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] status();
    return {busy, run, finished, error};
  endfunction

  function automatic logic [15:0] make_instr(input logic [2:0] dst, input logic [2:0] src,
                                             input logic [3:0] alu, input logic mode);
    logic [15:0] w;
    w = '0;
    w[DEST_MSB:DEST_LSB] = dst;
    w[SRC_MSB:SRC_LSB]   = src;
    w[ALU_MSB:ALU_LSB]   = alu;
    w[MODE_BIT]          = mode;
    return w;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    next_cycle();
    start     = 1'b0;
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    model_mem[a] = d;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_status"}, status(), 4'b0000);
    check({tag, "_instr"}, instruction, 16'h0000);
    check({tag, "_pc"}, pc, 0);
    @(negedge clk);
    reset   = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    prog_we = 1'b0;
  endtask

  // Runs one program of length len. fd/fw fix the control-unit response delay
  // and pulse width (0 = random). mode: 0 quiet, 1 random start/write noise
  // while busy, 2 start held high while busy, 3 write FFFF to address 1 while busy.
  task automatic exec_prog(input int len, input int fd, input int fw, input int mode);
    int eff, next_run, fin, dst, w, d, prev_w, k, a;
    bit ended;
    logic [15:0] data;
    logic [3:0]  exp_s;
    eff = (len > DEPTH) ? DEPTH : len;
    next_cycle();
    start    = 1'b1;
    prog_len = LW'(len);
    done     = 1'b0;
    prog_we  = 1'b0;
    if (mode == 1) begin
      a    = $urandom_range(0, DEPTH - 1);
      data = 16'($urandom);
      prog_we   = 1'b1;
      prog_addr = AW'(a);
      prog_data = data;
      model_mem[a] = data;
    end
    @(negedge clk);
    check("idle_before_start", status(), 4'b0000);
    fin      = (eff == 0) ? 1 : -1;
    next_run = (eff == 0) ? -1 : 2;
    dst = -1; w = 0; prev_w = 0; k = 0; ended = 1'b0;
    for (int t = 1; t < 4000; t++) begin
      next_cycle();
      start   = 1'b0;
      prog_we = 1'b0;
      if (fin < 0 || t <= fin) begin
        case (mode)
          1: begin
            start     = 1'($urandom);
            prog_len  = LW'($urandom);
            prog_we   = 1'($urandom);
            prog_addr = AW'($urandom);
            prog_data = 16'($urandom);
          end
          2: begin
            start    = 1'b1;
            prog_len = LW'(DEPTH);
          end
          3: begin
            prog_we   = 1'b1;
            prog_addr = AW'(1);
            prog_data = 16'hFFFF;
          end
          default: ;
        endcase
      end
      done = (dst >= 0 && t >= dst && t < dst + w);
      @(negedge clk);
      exp_s = {(fin < 0 || t <= fin), (t == next_run), (t == fin), 1'b0};
      check($sformatf("status@%0d", t), status(), exp_s);
      if (t == next_run) begin
        check($sformatf("instr_word%0d", k), instruction, model_mem[k]);
        check($sformatf("pc_word%0d", k), pc, k);
        d = (fd > 0) ? fd : $urandom_range((prev_w == 3) ? 2 : 1, TIMEOUT);
        w = (fw > 0) ? fw : $urandom_range(1, 3);
        dst    = t + d;
        prev_w = w;
        if (k == eff - 1) fin = t + d + 1;
        else              next_run = t + d + 2;
        k++;
      end
      if (fin >= 0 && t == fin + 1) begin
        if (eff > 0) check("pc_hold", pc, eff - 1);
        ended = 1'b1;
        break;
      end
    end
    done = 1'b0;
    if (!ended) check("exec_bound", 0, 1);
  endtask

  task automatic timeout_test();
    load(0, 16'hA001);
    load(1, 16'hA002);
    next_cycle();
    prog_we  = 1'b0;
    start    = 1'b1;
    prog_len = LW'(2);
    done     = 1'b0;
    for (int t = 1; t <= TIMEOUT + 5; t++) begin
      next_cycle();
      start = 1'b0;
      done  = 1'b1;
      @(negedge clk);
      check($sformatf("tmo_status@%0d", t), status(),
            {1'b1, (t == 2), 1'b0, (t >= 2 + TIMEOUT + 1)});
    end
    check("tmo_pc", pc, 0);
    for (int t = 0; t < 4; t++) begin
      next_cycle();
      start    = t[0];
      done     = ~t[0];
      prog_len = LW'(3);
      @(negedge clk);
      check("err_sticky", status(), 4'b1001);
    end
    next_cycle();
    apply_reset("err_reset");
  endtask

  task automatic reset_in_wait_test();
    next_cycle();
    start    = 1'b1;
    prog_len = LW'(3);
    done     = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      next_cycle();
      start = 1'b0;
      done  = (t == 5 || t == 6);
    end
    check("wait_w1_status", status(), 4'b1000);
    check("wait_w1_pc", pc, 1);
    #2;
    apply_reset("reset_wait");
    exec_prog(3, 2, 1, 0);
  endtask

  task automatic reset_in_issue_test();
    next_cycle();
    start    = 1'b1;
    prog_len = LW'(2);
    next_cycle();
    start = 1'b0;
    next_cycle();
    check("issue_run_high", run, 1);
    apply_reset("reset_issue");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; done = 1'b0;
    #3;
    check("rst_status", status(), 4'b0000);
    check("rst_instr", instruction, 16'h0000);
    check("rst_pc", pc, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      load(i, make_instr(3'($urandom), 3'($urandom), 4'($urandom), 1'($urandom)));

    // Three-word program, done 2-cycle pulse 3 cycles after each run.
    load(0, 16'h2418);
    load(1, 16'h4828);
    load(2, 16'h6C38);
    exec_prog(3, 3, 2, 0);

    // Empty program.
    exec_prog(0, 0, 0, 0);

    // done held high through WAIT: abort path.
    timeout_test();

    // Writes while busy are dropped.
    load(0, 16'h1111);
    load(1, 16'h2222);
    exec_prog(2, 4, 1, 3);
    exec_prog(2, 2, 1, 0);

    // Start held high while busy and during FINISH; response at the deadline.
    load(2, 16'h6C38);
    exec_prog(3, TIMEOUT, 1, 2);
    exec_prog(3, 1, 2, 0);

    reset_in_wait_test();
    reset_in_issue_test();

    // Randomized programs, including lengths above DEPTH.
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 3; j++)
        load($urandom_range(0, DEPTH - 1), 16'($urandom));
      exec_prog($urandom_range(0, DEPTH + 4), 0, 0, $urandom_range(0, 1));
    end
    exec_prog(2 * DEPTH - 1, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
